// File: rtl/tb_wait_event.sv
// tb_wait_event: WAIT engine watching one alias for rise/fall/change/match with timeout; define TB_WAIT_EVENT_SYNC_EN to add a 2-flop input sync
module tb_wait_event #(
  parameter int WAIT_ALIAS_NB = 5,
  parameter int WAIT_WIDTH = 32,
  parameter int TIMEOUT_WIDTH = 32,
  localparam int SW = (WAIT_ALIAS_NB > 1) ? $clog2(WAIT_ALIAS_NB) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [WAIT_ALIAS_NB*WAIT_WIDTH-1:0] i_wait,
  input  logic i_cmd_valid,
  output logic o_cmd_ready,
  input  logic [SW-1:0] i_cmd_sel,
  input  logic [1:0] i_cmd_mode,
  input  logic [WAIT_WIDTH-1:0] i_cmd_value,
  input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
  input  logic i_abort,
  output logic o_done,
  output logic o_hit,
  output logic o_timeout,
  output logic o_err,
  output logic [TIMEOUT_WIDTH-1:0] o_elapsed
);
  localparam int W = WAIT_WIDTH;
  localparam int T = TIMEOUT_WIDTH;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, nxt;
  logic [WAIT_ALIAS_NB*W-1:0] bus;
`ifdef TB_WAIT_EVENT_SYNC_EN
  logic [WAIT_ALIAS_NB*W-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_wait;
      sync2 <= sync1;
    end
  end
  assign bus = sync2;
`else
  assign bus = i_wait;
`endif
  logic [W-1:0] av [2**SW];
  logic [2**SW-1:0] ok;
  for (genvar k = 0; k < 2**SW; k++) begin : g_alias
    if (k < WAIT_ALIAS_NB) begin : g_in
      assign av[k] = bus[k*W +: W];
      assign ok[k] = 1'b1;
    end else begin : g_out
      assign av[k] = '0;
      assign ok[k] = 1'b0;
    end
  end
  logic [SW-1:0] sel;
  logic [1:0] mode;
  logic [W-1:0] value, prev, cur;
  logic [T-1:0] lim, cnt;
  logic accept, ev, expire;
  always_comb begin
    cur = av[sel];
    accept = i_cmd_valid && state == S_IDLE;
    ev = mode == 2'b00 ? !prev[0] && cur[0] :
         mode == 2'b01 ? prev[0] && !cur[0] :
         mode == 2'b10 ? cur != prev : cur == value;
    expire = lim != '0 && cnt == lim - T'(1);
    nxt = state == S_IDLE ? (accept ? (ok[i_cmd_sel] ? S_WAIT : S_DONE) : S_IDLE) :
          state == S_WAIT ? (i_abort ? S_IDLE : (ev || expire) ? S_DONE : S_WAIT) : S_IDLE;
    o_cmd_ready = state == S_IDLE;
    o_done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
      mode <= '0;
      value <= '0;
      lim <= '0;
      cnt <= '0;
      prev <= '0;
      o_hit <= 1'b0;
      o_timeout <= 1'b0;
      o_err <= 1'b0;
      o_elapsed <= '0;
    end else if (accept) begin
      sel <= i_cmd_sel;
      mode <= i_cmd_mode;
      value <= i_cmd_value;
      lim <= i_cmd_timeout;
      cnt <= '0;
      prev <= av[i_cmd_sel];
      o_hit <= 1'b0;
      o_timeout <= 1'b0;
      o_err <= !ok[i_cmd_sel];
    end else if (state == S_WAIT && !i_abort) begin
      prev <= cur;
      if (ev) begin
        o_hit <= 1'b1;
        o_elapsed <= cnt;
      end else if (expire) begin
        o_timeout <= 1'b1;
        o_elapsed <= lim;
      end else if (lim != '0 || ~&cnt) cnt <= cnt + T'(1);
    end
  end
endmodule
